// File: rtl/keccak_rate_buffer.sv
// keccak_rate_buffer: packs IN_WIDTH-bit message words into RATE-bit blocks,
// applies Keccak pad10*1 padding (byte granularity) on the message's last
// word, and queues completed blocks in a NUM_SLOTS-deep FIFO.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-low reset
//   in_data/in_valid/in_last/in_bytes/in_ready   word input handshake
//   out_data/out_valid/out_last/out_ready        block output handshake
//   fill_level            number of blocks held in the FIFO
//   msg_count             (KECCAK_RATE_BUFFER_STATS_EN only) messages drained
//
// Optional feature: define KECCAK_RATE_BUFFER_STATS_EN to add msg_count.
module keccak_rate_buffer #(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned RATE      = 256,
  parameter int unsigned NUM_SLOTS = 2
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [IN_WIDTH-1:0]              in_data,
  input  logic                             in_valid,
  input  logic                             in_last,
  input  logic [$clog2(IN_WIDTH/8):0]      in_bytes,
  output logic                             in_ready,
  output logic [RATE-1:0]                  out_data,
  output logic                             out_valid,
  output logic                             out_last,
  input  logic                             out_ready,
  output logic [$clog2(NUM_SLOTS+1)-1:0]   fill_level
`ifdef KECCAK_RATE_BUFFER_STATS_EN
  ,
  output logic [31:0]                      msg_count
`endif
);

  localparam int unsigned WORDS = RATE / IN_WIDTH;
  localparam int unsigned BW    = IN_WIDTH / 8;
  localparam int unsigned RB    = RATE / 8;
  localparam int unsigned CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int unsigned FL_W  = $clog2(NUM_SLOTS + 1);

  typedef enum logic {FILL = 1'b0, EXTRA = 1'b1} state_e;

  typedef struct packed {
    logic            last;
    logic [RATE-1:0] data;
  } blk_t;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RATE-1:0] asm_q, asm_d;
  blk_t            mem_q [NUM_SLOTS];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [FL_W-1:0] fill_q;

  logic            not_full, accept, push, pop;
  blk_t            push_blk;
  logic [RATE-1:0] blk_pack;
  int unsigned     nb, pos;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == NUM_SLOTS - 1) ? '0 : p + PTR_W'(1);
  endfunction

  assign not_full   = fill_q < FL_W'(NUM_SLOTS);
  // in_ready depends only on registered state (and is held low in reset)
  assign in_ready   = reset && (state_q == FILL) && not_full;
  assign accept     = in_valid && in_ready;
  assign out_valid  = (fill_q != '0);
  assign pop        = out_valid && out_ready;
  assign out_data   = mem_q[rd_q].data;
  assign out_last   = mem_q[rd_q].last;
  assign fill_level = fill_q;

  // Block image with the incoming word merged in; on a last word, invalid
  // bytes and all later words are zero and pad10*1 is applied when it fits.
  always_comb begin
    nb       = (32'(in_bytes) > BW) ? BW : 32'(in_bytes);
    pos      = 32'(cnt_q) * BW + nb;
    blk_pack = '0;
    for (int unsigned b = 0; b < RB; b++) begin
      if (b / BW < 32'(cnt_q)) begin
        blk_pack[b*8 +: 8] = asm_q[b*8 +: 8];
      end else if ((b / BW == 32'(cnt_q)) && (!in_last || (b % BW) < nb)) begin
        blk_pack[b*8 +: 8] = in_data[(b % BW)*8 +: 8];
      end
    end
    if (in_last && pos < RB) begin
      blk_pack[pos*8 +: 8]    = blk_pack[pos*8 +: 8] | 8'h01;
      blk_pack[RATE-8 +: 8]   = blk_pack[RATE-8 +: 8] | 8'h80;
    end
  end

  // Next-state: word packing, block commit, trailing pad-only block
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    asm_d    = asm_q;
    push     = 1'b0;
    push_blk = '0;
    case (state_q)
      FILL: begin
        if (accept) begin
          asm_d = blk_pack;
          if (in_last) begin
            cnt_d         = '0;
            push          = 1'b1;
            push_blk.data = blk_pack;
            push_blk.last = (pos < RB);
            // Message filled the block exactly: padding needs its own block
            if (pos >= RB) state_d = EXTRA;
          end else if (32'(cnt_q) == WORDS - 1) begin
            cnt_d         = '0;
            push          = 1'b1;
            push_blk.data = blk_pack;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      EXTRA: begin
        if (not_full) begin
          push                     = 1'b1;
          push_blk.last            = 1'b1;
          push_blk.data[7:0]       = 8'h01;
          push_blk.data[RATE-8 +: 8] = 8'h80;
          state_d                  = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State, assembly register and block FIFO
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= FILL;
      cnt_q   <= '0;
      asm_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      fill_q  <= '0;
      for (int i = 0; i < int'(NUM_SLOTS); i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      if (push) begin
        mem_q[wr_q] <= push_blk;
        wr_q        <= ptr_inc(wr_q);
      end
      if (pop) rd_q <= ptr_inc(rd_q);
      if (push && !pop)      fill_q <= fill_q + FL_W'(1);
      else if (!push && pop) fill_q <= fill_q - FL_W'(1);
    end
  end

`ifdef KECCAK_RATE_BUFFER_STATS_EN
  // Count final blocks handed to the consumer
  always_ff @(posedge clock) begin
    if (!reset) msg_count <= '0;
    else if (pop && out_last) msg_count <= msg_count + 32'd1;
  end
`endif

endmodule
